// File: rtl/seq_stage_controller_pkg.sv
// Shared types and constants for the sequential Y86-style stage controller.
// Holds the state encoding, instruction codes, status codes and the registered output bundle.
package seq_stage_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALTED    = 3'd7
    } state_e;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    // Last wait-counter value tolerated before a data-memory timeout
    localparam logic [3:0] MEM_TIMEOUT = 4'd15;

    typedef struct packed {
        logic fetch_en;
        logic decode_en;
        logic execute_en;
        logic memory_en;
        logic wb_en;
        logic pc_en;
        logic mem_req;
        logic rf_we_e;
        logic rf_we_m;
        logic cc_we;
        logic busy;
    } stage_out_t;

endpackage

// File: rtl/seq_stage_controller_icode_classify.sv
// Combinational icode classifier: which stages and register writes an instruction needs.
module seq_icode_classify
    import seq_stage_controller_pkg::*;
(
    input  logic [3:0] icode,
    output logic       needs_mem,
    output logic       writes_e,
    output logic       writes_m,
    output logic       is_cmov,
    output logic       is_valid
);

    // Per-icode attribute decode; anything above POPQ is an illegal instruction
    always_comb begin
        needs_mem = 1'b0;
        writes_e  = 1'b0;
        writes_m  = 1'b0;
        is_cmov   = 1'b0;
        is_valid  = 1'b1;
        case (icode)
            ICODE_HALT, ICODE_NOP, ICODE_JXX: begin
                is_valid = 1'b1;
            end
            ICODE_RRMOVQ: begin
                writes_e = 1'b1;
                is_cmov  = 1'b1;
            end
            ICODE_IRMOVQ, ICODE_OPQ: begin
                writes_e = 1'b1;
            end
            ICODE_RMMOVQ: begin
                needs_mem = 1'b1;
            end
            ICODE_MRMOVQ: begin
                needs_mem = 1'b1;
                writes_m  = 1'b1;
            end
            ICODE_CALL, ICODE_RET, ICODE_PUSHQ: begin
                needs_mem = 1'b1;
                writes_e  = 1'b1;
            end
            ICODE_POPQ: begin
                needs_mem = 1'b1;
                writes_e  = 1'b1;
                writes_m  = 1'b1;
            end
            default: begin
                is_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_stage_controller.sv
// Sequencer stepping one instruction at a time through FETCH..PCUPD with fault halting.
// Outputs are registered from the next-state decode so they line up exactly with the state register.
module seq_stage_controller
    import seq_stage_controller_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        imem_error,
    input  logic        Cnd,
    input  logic        mem_ready,
    input  logic        dmem_error,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        execute_en,
    output logic        memory_en,
    output logic        wb_en,
    output logic        pc_en,
    output logic        mem_req,
    output logic        rf_we_e,
    output logic        rf_we_m,
    output logic        cc_we,
    output logic [1:0]  stat,
    output logic        busy,
    output logic [15:0] instr_count
);

    state_e      state_r, state_nx_s;
    logic [3:0]  icode_r, icode_nx_s;
    logic        cnd_r, cnd_nx_s;
    logic [3:0]  wait_r, wait_nx_s;
    logic [1:0]  stat_r, stat_nx_s;
    logic [15:0] count_r, count_nx_s;
    stage_out_t  out_r, out_nx_s;

    logic needs_mem_s, writes_e_s, writes_m_s, is_cmov_s, is_valid_s;

    seq_icode_classify u_classify (
        .icode     (icode_r),
        .needs_mem (needs_mem_s),
        .writes_e  (writes_e_s),
        .writes_m  (writes_m_s),
        .is_cmov   (is_cmov_s),
        .is_valid  (is_valid_s)
    );

    // Next-state, latched-context and counter update logic
    always_comb begin
        state_nx_s = state_r;
        icode_nx_s = icode_r;
        cnd_nx_s   = cnd_r;
        wait_nx_s  = wait_r;
        stat_nx_s  = stat_r;
        count_nx_s = count_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = S_FETCH;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (imem_error) begin
                    state_nx_s = S_HALTED;
                    stat_nx_s  = STAT_ADR;
                end else begin
                    icode_nx_s = icode;
                    state_nx_s = S_DECODE;
                end
            end
            S_DECODE: begin
                if (icode_r == ICODE_HALT) begin
                    state_nx_s = S_HALTED;
                    stat_nx_s  = STAT_HLT;
                end else if (!is_valid_s) begin
                    state_nx_s = S_HALTED;
                    stat_nx_s  = STAT_INS;
                end else begin
                    state_nx_s = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                cnd_nx_s = Cnd;
                if (needs_mem_s) begin
                    state_nx_s = S_MEMORY;
                    wait_nx_s  = 4'd0;
                end else begin
                    state_nx_s = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (dmem_error) begin
                        state_nx_s = S_HALTED;
                        stat_nx_s  = STAT_ADR;
                    end else begin
                        state_nx_s = S_WRITEBACK;
                    end
                end else if (wait_r == MEM_TIMEOUT) begin
                    state_nx_s = S_HALTED;
                    stat_nx_s  = STAT_ADR;
                end else begin
                    wait_nx_s = wait_r + 4'd1;
                end
            end
            S_WRITEBACK: begin
                state_nx_s = S_PCUPD;
            end
            S_PCUPD: begin
                state_nx_s = S_FETCH;
                count_nx_s = count_r + 16'd1;
            end
            S_HALTED: begin
                state_nx_s = S_HALTED;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Moore decode of the upcoming state; cmov uses the Cnd value being latched this cycle
    always_comb begin
        out_nx_s      = '0;
        out_nx_s.busy = (state_nx_s != S_IDLE) && (state_nx_s != S_HALTED);
        case (state_nx_s)
            S_FETCH:     out_nx_s.fetch_en = 1'b1;
            S_DECODE:    out_nx_s.decode_en = 1'b1;
            S_EXECUTE: begin
                out_nx_s.execute_en = 1'b1;
                out_nx_s.cc_we      = (icode_r == ICODE_OPQ);
            end
            S_MEMORY: begin
                out_nx_s.memory_en = 1'b1;
                out_nx_s.mem_req   = 1'b1;
            end
            S_WRITEBACK: begin
                out_nx_s.wb_en   = 1'b1;
                out_nx_s.rf_we_e = writes_e_s && (!is_cmov_s || cnd_nx_s);
                out_nx_s.rf_we_m = writes_m_s;
            end
            S_PCUPD:     out_nx_s.pc_en = 1'b1;
            default:     out_nx_s.busy = out_nx_s.busy;
        endcase
    end

    // Control state, latched instruction context, wait counter and retired count
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_IDLE;
            icode_r <= 4'd0;
            cnd_r   <= 1'b0;
            wait_r  <= 4'd0;
            stat_r  <= STAT_AOK;
            count_r <= 16'd0;
        end else begin
            state_r <= state_nx_s;
            icode_r <= icode_nx_s;
            cnd_r   <= cnd_nx_s;
            wait_r  <= wait_nx_s;
            stat_r  <= stat_nx_s;
            count_r <= count_nx_s;
        end
    end

    // Output register for glitch-free strobes
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_r <= '0;
        end else begin
            out_r <= out_nx_s;
        end
    end

    assign fetch_en    = out_r.fetch_en;
    assign decode_en   = out_r.decode_en;
    assign execute_en  = out_r.execute_en;
    assign memory_en   = out_r.memory_en;
    assign wb_en       = out_r.wb_en;
    assign pc_en       = out_r.pc_en;
    assign mem_req     = out_r.mem_req;
    assign rf_we_e     = out_r.rf_we_e;
    assign rf_we_m     = out_r.rf_we_m;
    assign cc_we       = out_r.cc_we;
    assign busy        = out_r.busy;
    assign stat        = stat_r;
    assign instr_count = count_r;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Scoreboard bench: a cycle-level model queues expected outputs with the stimulus for each cycle.
module tb_seq_stage_controller;
    import seq_stage_controller_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'd0;
    logic        imem_error = 1'b0;
    logic        Cnd = 1'b0;
    logic        mem_ready = 1'b0;
    logic        dmem_error = 1'b0;
    logic        fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en;
    logic        mem_req, rf_we_e, rf_we_m, cc_we, busy;
    logic [1:0]  stat;
    logic [15:0] instr_count;

    seq_stage_controller dut (
        .CLK(CLK), .RST(RST), .start(start), .icode(icode), .imem_error(imem_error),
        .Cnd(Cnd), .mem_ready(mem_ready), .dmem_error(dmem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
        .memory_en(memory_en), .wb_en(wb_en), .pc_en(pc_en), .mem_req(mem_req),
        .rf_we_e(rf_we_e), .rf_we_m(rf_we_m), .cc_we(cc_we), .stat(stat),
        .busy(busy), .instr_count(instr_count)
    );

    always #5 CLK = ~CLK;

    // bit order: fetch,decode,execute,memory,wb,pc,mem_req,rf_we_e,rf_we_m,cc_we,busy
    localparam logic [10:0] V_IDLE = 11'h000;
    localparam logic [10:0] V_F    = 11'h401;
    localparam logic [10:0] V_D    = 11'h201;
    localparam logic [10:0] V_E    = 11'h101;
    localparam logic [10:0] V_M    = 11'h091;
    localparam logic [10:0] V_W    = 11'h041;
    localparam logic [10:0] V_P    = 11'h021;
    localparam logic [10:0] V_WE   = 11'h008;
    localparam logic [10:0] V_WM   = 11'h004;
    localparam logic [10:0] V_CC   = 11'h002;

    typedef struct packed {
        logic [10:0] vec;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        go;
        logic        rst;
        logic [3:0]  ic;
        logic        ierr;
        logic        c;
        logic        mrdy;
        logic        derr;
    } entry_t;

    entry_t      sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_count = 16'd0;
    logic [1:0]  model_stat = STAT_AOK;
    logic [10:0] obs_vec;

    assign obs_vec = {fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en,
                      mem_req, rf_we_e, rf_we_m, cc_we, busy};

    task automatic push(input logic [10:0] v, input logic go, input logic rs, input logic [3:0] ic,
                        input logic ie, input logic c, input logic mr, input logic de);
        entry_t e;
        e.vec = v; e.st = model_stat; e.cnt = model_count; e.go = go; e.rst = rs;
        e.ic = ic; e.ierr = ie; e.c = c; e.mrdy = mr; e.derr = de;
        sbq.push_back(e);
    endtask

    // Expected per-cycle trace of one instruction starting at FETCH
    task automatic model_instr(input logic [3:0] ic, input logic c, input int rdy_at,
                               input logic derr, input logic ierr, input logic noise);
        logic we_e;
        logic we_m;
        int   k;
        push(V_F, 1'b0, 1'b0, ic, ierr, 1'($urandom), noise, 1'b0);
        if (ierr) begin model_stat = STAT_ADR; return; end
        push(V_D, 1'b0, 1'b0, 4'($urandom), 1'b0, 1'($urandom), noise, 1'b0);
        if (ic == 4'd0) begin model_stat = STAT_HLT; return; end
        if (ic > 4'd11) begin model_stat = STAT_INS; return; end
        push((ic == 4'd6) ? (V_E | V_CC) : V_E, 1'b0, 1'b0, 4'($urandom), 1'b0, c, noise, 1'b0);
        if ((ic == 4'd4) || (ic == 4'd5) || (ic >= 4'd8)) begin
            k = 0;
            while (k < 16) begin
                if (k == rdy_at) begin
                    push(V_M, 1'b0, 1'b0, 4'($urandom), 1'b0, 1'($urandom), 1'b1, derr);
                    if (derr) begin model_stat = STAT_ADR; return; end
                    k = 99;
                end else begin
                    push(V_M, 1'b0, 1'b0, 4'($urandom), 1'b0, 1'($urandom), 1'b0, 1'($urandom));
                    if (k == 15) begin model_stat = STAT_ADR; return; end
                    k++;
                end
            end
        end
        we_e = (ic == 4'd3) || (ic == 4'd6) || (ic >= 4'd8) || ((ic == 4'd2) && c);
        we_m = (ic == 4'd5) || (ic == 4'd11);
        push(V_W | (we_e ? V_WE : V_IDLE) | (we_m ? V_WM : V_IDLE),
             1'b0, 1'b0, 4'($urandom), 1'b0, 1'($urandom), noise, 1'b0);
        push(V_P, 1'b0, 1'b0, 4'($urandom), 1'b0, 1'($urandom), noise, 1'b0);
        model_count = model_count + 16'd1;
    endtask

    // Pop each expected cycle, compare against the DUT, then apply that cycle's stimulus
    task automatic drain();
        entry_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (obs_vec !== e.vec) begin
                errors++;
                $display("FAIL strobes t=%0t: got %b want %b", $time, obs_vec, e.vec);
            end
            checks++;
            if (stat !== e.st) begin
                errors++;
                $display("FAIL stat t=%0t: got %0d want %0d", $time, stat, e.st);
            end
            checks++;
            if (instr_count !== e.cnt) begin
                errors++;
                $display("FAIL instr_count t=%0t: got %h want %h", $time, instr_count, e.cnt);
            end
            RST = e.rst; start = e.go; icode = e.ic; imem_error = e.ierr;
            Cnd = e.c; mem_ready = e.mrdy; dmem_error = e.derr;
            @(posedge CLK); #1;
        end
    endtask

    task automatic apply_reset();
        RST = 1'b1; start = 1'b0; mem_ready = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        model_count = 16'd0;
        model_stat = STAT_AOK;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b1; icode = 4'h3; imem_error = 1'b1;
        Cnd = 1'b1; mem_ready = 1'b1; dmem_error = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (obs_vec !== V_IDLE) begin errors++; $display("FAIL reset_outputs: got %b want %b", obs_vec, V_IDLE); end
        checks++;
        if (stat !== STAT_AOK) begin errors++; $display("FAIL reset_stat: got %0d want 0", stat); end
        checks++;
        if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %h want 0", instr_count); end
        RST = 1'b0; start = 1'b0; imem_error = 1'b0; Cnd = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0;
        model_count = 16'd0;
        model_stat = STAT_AOK;
    endtask

    task automatic test_alu_imm();
        push(V_IDLE, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_instr(4'h3, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        drain();
        checks++;
        if (instr_count !== 16'd1) begin errors++; $display("FAIL irmovq_count: got %h want 0001", instr_count); end
    endtask

    task automatic test_mem_load();
        model_instr(4'h5, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_cmov_opq();
        model_instr(4'h2, 1'b0, -1, 1'b0, 1'b0, 1'b1);
        model_instr(4'h2, 1'b1, -1, 1'b0, 1'b0, 1'b1);
        model_instr(4'h6, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq [8] = '{4'h4, 4'h8, 4'h9, 4'hA, 4'hB, 4'h1, 4'h7, 4'h3};
        for (int i = 0; i < 8; i++) begin
            model_instr(seq[i], 1'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        end
        drain();
        checks++;
        if (instr_count !== 16'd13) begin errors++; $display("FAIL b2b_count: got %0d want 13", instr_count); end
    endtask

    task automatic test_reset_mid_memory();
        push(V_F, 1'b0, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        push(V_D, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(V_E, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        push(V_M, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(V_M, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        model_count = 16'd0;
        model_stat = STAT_AOK;
        push(V_IDLE, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(V_IDLE, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_mem_timeout();
        push(V_IDLE, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_instr(4'h4, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        repeat (3) push(V_IDLE, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
        checks++;
        if (stat !== STAT_ADR) begin errors++; $display("FAIL timeout_stat: got %0d want 2", stat); end
    endtask

    task automatic test_faults();
        logic [3:0] ics  [4] = '{4'h0, 4'hC, 4'h3, 4'h5};
        logic       ierr [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       derr [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            apply_reset();
            push(V_IDLE, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            model_instr(ics[i], 1'b1, 1, derr[i], ierr[i], 1'b0);
            repeat (2) push(V_IDLE, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
            drain();
        end
    endtask

    task automatic test_count_wrap();
        apply_reset();
        force dut.count_r = 16'hFFFF;
        @(posedge CLK); #1;
        release dut.count_r;
        model_count = 16'hFFFF;
        push(V_IDLE, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_instr(4'h1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        drain();
        checks++;
        if (instr_count !== 16'h0000) begin errors++; $display("FAIL count_wrap: got %h want 0000", instr_count); end
    endtask

    initial begin
        test_reset();
        test_alu_imm();
        test_mem_load();
        test_cmov_opq();
        test_back_to_back();
        test_reset_mid_memory();
        test_mem_timeout();
        test_faults();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_stage_controller.md
SEQ_STAGE_CONTROLLER -- requirements
Module: seq_stage_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports declared in the order below.
REQ-002 CLK  in  1  system clock, all state changes on its rising edge.
REQ-003 RST  in  1  synchronous active-high reset.
REQ-004 start  in  1  one-cycle request to begin executing; honoured only in IDLE.
REQ-005 icode  in  4  instruction code from fetch logic, valid during FETCH.
REQ-006 imem_error  in  1  instruction-memory fault, valid during FETCH.
REQ-007 Cnd  in  1  branch/cmov condition from ALU, valid during EXECUTE.
REQ-008 mem_ready  in  1  data-memory completion, meaningful only in MEMORY.
REQ-009 dmem_error  in  1  data-memory fault, qualified by mem_ready.
REQ-010 fetch_en, decode_en, execute_en, memory_en, wb_en, pc_en  out  1 each  stage strobes, at most one high per cycle.
REQ-011 mem_req  out  1  data-memory request, high throughout MEMORY.
REQ-012 rf_we_e, rf_we_m  out  1 each  register-file destE/destM write enables.
REQ-013 cc_we  out  1  condition-code write enable.
REQ-014 stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS.
REQ-015 busy  out  1  high in any state except IDLE and HALTED.
REQ-016 instr_count  out  16  retired-instruction counter.

Function
REQ-017 States SHALL be IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED; stage strobes are Moore outputs of the state.
REQ-018 IDLE->FETCH on start; FETCH->DECODE->EXECUTE unconditionally, except the faults in REQ-019.
REQ-019 In FETCH, imem_error SHALL go to HALTED with stat=ADR; otherwise icode is latched at FETCH exit; in DECODE, latched icode 0 -> HALTED with stat=HLT, icode >0xB -> HALTED with stat=INS.
REQ-020 EXECUTE SHALL latch Cnd; next is MEMORY for icodes 4,5,8,9,A,B, otherwise WRITEBACK.
REQ-021 cc_we SHALL be high for exactly the EXECUTE cycle when icode=6.
REQ-022 MEMORY SHALL hold mem_req until mem_ready; on mem_ready with dmem_error=0 go to WRITEBACK; with dmem_error=1 go to HALTED, stat=ADR, no register writes.
REQ-023 A 4-bit wait counter SHALL clear on MEMORY entry and increment each MEMORY cycle without mem_ready; after 15 waiting cycles (16th MEMORY cycle without mem_ready) go to HALTED, stat=ADR.
REQ-024 mem_ready asserted in the first MEMORY cycle SHALL complete MEMORY in one cycle; mem_ready outside MEMORY is ignored.
REQ-025 In WRITEBACK, rf_we_e SHALL be high for icodes 3,6,8,9,A,B and for icode 2 only if latched Cnd=1; rf_we_m high for icodes 5,B; both low in all other states.
REQ-026 WRITEBACK->PCUPD->FETCH; instr_count increments by 1 on PCUPD exit, wrapping 0xFFFF->0x0000.
REQ-027 Latency: non-memory instruction 5 cycles FETCH to FETCH; memory instruction 6 + wait cycles.
REQ-028 start while busy or in HALTED SHALL be ignored; HALTED is left only by RST.
REQ-029 stat SHALL remain AOK while running and hold its fault value in HALTED.

Reset
REQ-030 RST SHALL take priority over every other input, including mid-MEMORY and in HALTED.
REQ-031 Reset values: state=IDLE, all strobes/enables/mem_req/busy=0, stat=AOK, instr_count=0, latched icode=0, latched Cnd=0, wait counter=0.

Structure
REQ-032 A shared package SHALL hold the state enumeration, icode constants (HALT..POPQ), stat codes and MEM_TIMEOUT=15.
REQ-033 Icode classification (needs_mem, writes_e, writes_m, is_cmov, is_valid) SHALL live in one combinational sub-module seq_icode_classify.

Verification
REQ-034 icode=3, start pulse, mem_ready=0 -> strobes FETCH..PCUPD over 5 cycles, rf_we_e=1 in WRITEBACK only, instr_count 0->1.
REQ-035 icode=5, mem_ready asserted on 3rd MEMORY cycle -> mem_req high 3 cycles, rf_we_m=1 in WRITEBACK, 8 cycles FETCH to FETCH.
REQ-036 icode=2 with Cnd=0, then again with Cnd=1 -> rf_we_e 0 then 1; icode=6 -> cc_we one cycle.
REQ-037 icode=4, mem_ready never -> HALTED after 16 MEMORY cycles, stat=2, busy=0; start ignored afterwards.
REQ-038 icode=0 -> HALTED stat=1; icode=0xC -> stat=3; imem_error in FETCH -> stat=2; no rf_we in any case.
REQ-039 RST asserted during MEMORY -> next cycle IDLE, outputs at reset values; instr_count at 0xFFFF wraps to 0 after one more instruction.
